mult_hilo: RTL and testbench
============================

MULT_HILO -- requirements
Module: mult_hilo

Interface
REQ-001 Parameter LATENCY, default 2, number of BUSY cycles before the result is written (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 mul_valid  input  1  EXE-stage multiply request.
REQ-005 mul_op  input  2  bit0 = signed (MULT/MADD), bit1 = accumulate (MADD/MADDU).
REQ-006 mul_src1, mul_src2  input  32 each  rs/rt operands.
REQ-007 mul_ready  output  1  block idle; a request is accepted this cycle.
REQ-008 mul_done  output  1  one-cycle pulse; HI/LO update at the end of this cycle.
REQ-009 hilo_wen  input  2  bit1 = MTHI, bit0 = MTLO.
REQ-010 hilo_wdata  input  32  MTHI/MTLO data.
REQ-011 hi, lo  output  32 each  architectural HI and LO registers.
REQ-012 mult_op1, mult_op2  output  32 each  unsigned operands driven to the multiplier.
REQ-013 mult_product  input  64  unsigned product returned by the multiplier.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 mul_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a clock edge where mul_valid=1 and mul_ready=1.
REQ-017 On accept, the block SHALL register |src1|, |src2|, neg = signed & (src1[31]^src2[31]) and the accumulate flag, then enter BUSY.
REQ-018 For unsigned ops, operands SHALL be taken as-is; |0x80000000| SHALL be 0x80000000 (32-bit unsigned, no overflow).
REQ-019 mult_op1/mult_op2 SHALL come from the registered operands and stay stable from BUSY through DONE.
REQ-020 The block SHALL stay in BUSY for exactly LATENCY cycles using a down-counter, then enter DONE.
REQ-021 In DONE, the result SHALL be R = neg ? (~mult_product + 1) : mult_product, computed mod 2^64.
REQ-022 In DONE, {hi,lo} SHALL be written with R, or with {hi,lo} + R (mod 2^64) when accumulating.
REQ-023 In DONE, mul_done SHALL be 1; the next state SHALL be IDLE.
REQ-024 Timing: accept in cycle 0, BUSY in cycles 1..LATENCY, DONE in cycle LATENCY+1; new HI/LO and mul_ready=1 in cycle LATENCY+2.
REQ-025 mul_valid outside IDLE SHALL be ignored; upstream holds the request.
REQ-026 hilo_wen SHALL be honoured only in IDLE and SHALL be ignored in BUSY/DONE.
REQ-027 If hilo_wen and an accepted request coincide in IDLE, the MTHI/MTLO write SHALL occur first, and the accumulate in DONE SHALL use that written value.
REQ-028 hilo_wen=2'b11 SHALL write hilo_wdata to both hi and lo.
REQ-029 A back-to-back request held high SHALL be accepted in cycle LATENCY+2 with no bubble.

Reset
REQ-030 When resetn=0, the block SHALL immediately enter IDLE with hi=0, lo=0, mul_done=0, counter=0, operand registers=0 and mul_ready=1 (once the FSM is in IDLE).
REQ-031 A reset during BUSY or DONE SHALL abort the operation, with no HI/LO write after release.

Configuration
REQ-032 With macro MULT_HILO_ACC_EN defined, mul_op[1] SHALL select accumulate per REQ-022.
REQ-033 Without MULT_HILO_ACC_EN, mul_op[1] SHALL be ignored, every op SHALL overwrite {hi,lo}, and no 64-bit adder SHALL be synthesised.

Verification
REQ-034 MULT with src1=0xFFFFFFFD (-3) and src2=5, LATENCY=2 -> mul_done in cycle 3, hi=0xFFFFFFFF, lo=0xFFFFFFF1 in cycle 4.
REQ-035 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-036 MADD with hi=0, lo=1 (set by MTHI/MTLO) and 2*3 -> lo=7, hi=0; with MULT_HILO_ACC_EN off -> lo=6.
REQ-037 mul_valid held high for two requests -> second accepted in cycle LATENCY+2; a pulse of MTLO during BUSY leaves lo unchanged.
REQ-038 resetn dropped in cycle 1 of a MULT 7*7 -> hi=lo=0, mul_done never pulses, mul_ready=1 after release.

Source files
------------

// File: rtl/mult_hilo.sv
// Multi-cycle MULT/MULTU/MADD/MADDU sequencer that owns the architectural HI/LO pair.
// Define MULT_HILO_ACC_EN to enable accumulate (MADD/MADDU) into {hi,lo}.
module mult_hilo #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mul_valid,
    input  logic [1:0]  mul_op,
    input  logic [31:0] mul_src1,
    input  logic [31:0] mul_src2,
    output logic        mul_ready,
    output logic        mul_done,
    input  logic [1:0]  hilo_wen,
    input  logic [31:0] hilo_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] mult_product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        mul_ready_q, mul_ready_d;
    logic        mul_done_q, mul_done_d;
    logic [63:0] res_s;
    logic [63:0] hilo_new_s;

    // Magnitude of a possibly-signed operand; |0x80000000| wraps to itself.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) begin
            abs32 = ~v + 32'd1;
        end else begin
            abs32 = v;
        end
    endfunction

    // Re-apply the sign to the unsigned product (two's complement, mod 2^64).
    always_comb begin
        if (neg_q) begin
            res_s = ~mult_product + 64'd1;
        end else begin
            res_s = mult_product;
        end
    end

`ifdef MULT_HILO_ACC_EN
    logic acc_q, acc_d;

    // Accumulate into the current {hi,lo} when the accepted op asked for it.
    always_comb begin
        if (acc_q) begin
            hilo_new_s = {hi_q, lo_q} + res_s;
        end else begin
            hilo_new_s = res_s;
        end
    end

    // Accumulate flag register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic op_unused_s;
    assign op_unused_s = mul_op[1];

    // Without accumulate every op simply overwrites {hi,lo}.
    always_comb begin
        hilo_new_s = res_s;
    end
`endif

    // Next-state, operand capture and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULT_HILO_ACC_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // MTHI/MTLO land before any accepted op, so a MADD sees them.
                if (hilo_wen[1]) begin
                    hi_d = hilo_wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (hilo_wen[0]) begin
                    lo_d = hilo_wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (mul_valid && mul_ready_q) begin
                    op1_d   = abs32(mul_src1, mul_op[0]);
                    op2_d   = abs32(mul_src2, mul_op[0]);
                    neg_d   = mul_op[0] & (mul_src1[31] ^ mul_src2[31]);
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
`ifdef MULT_HILO_ACC_EN
                    acc_d   = mul_op[1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                hi_d    = hilo_new_s[63:32];
                lo_d    = hilo_new_s[31:0];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mul_ready_d = (state_d == ST_IDLE);
        mul_done_d  = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            neg_q       <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            mul_ready_q <= 1'b1;
            mul_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            neg_q       <= neg_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mul_ready_q <= mul_ready_d;
            mul_done_q  <= mul_done_d;
        end
    end

    assign mul_ready = mul_ready_q;
    assign mul_done  = mul_done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mult_op1  = op1_q;
    assign mult_op2  = op2_q;

endmodule

// File: tb/tb_mult_hilo.sv
// Directed self-checking bench for mult_hilo; the bench supplies the unsigned multiplier.
module tb_mult_hilo;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        resetn;
    logic        mul_valid;
    logic [1:0]  mul_op;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_ready;
    logic        mul_done;
    logic [1:0]  hilo_wen;
    logic [31:0] hilo_wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] mult_product;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    mult_hilo #(.LATENCY(LAT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mul_valid    (mul_valid),
        .mul_op       (mul_op),
        .mul_src1     (mul_src1),
        .mul_src2     (mul_src2),
        .mul_ready    (mul_ready),
        .mul_done     (mul_done),
        .hilo_wen     (hilo_wen),
        .hilo_wdata   (hilo_wdata),
        .hi           (hi),
        .lo           (lo),
        .mult_op1     (mult_op1),
        .mult_op2     (mult_op2),
        .mult_product (mult_product)
    );

    assign mult_product = {32'd0, mult_op1} * {32'd0, mult_op2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue one op at the current cycle and follow it to the HI/LO update.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({tag, "_ready0"}, 64'(mul_ready), 64'd1);
        mul_valid = 1'b1;
        mul_op    = op;
        mul_src1  = a;
        mul_src2  = b;
        step();
        mul_valid = 1'b0;
        check({tag, "_busy"}, 64'(mul_ready), 64'd0);
        for (int i = 1; i < LAT; i++) step();
        check({tag, "_nodone"}, 64'(mul_done), 64'd0);
        step();
        check({tag, "_done"}, 64'(mul_done), 64'd1);
        step();
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_ready"}, {62'd0, mul_ready, mul_done}, 64'd2);
    endtask

    initial begin
        resetn     = 1'b0;
        mul_valid  = 1'b0;
        mul_op     = 2'b00;
        mul_src1   = 32'd0;
        mul_src2   = 32'd0;
        hilo_wen   = 2'b00;
        hilo_wdata = 32'd0;
        step();
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ctl", {62'd0, mul_ready, mul_done}, 64'd2);
        check("rst_ops", {mult_op1, mult_op2}, 64'd0);
        resetn = 1'b1;
        step();

        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult_min2", 2'b01, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("multu_min2", 2'b00, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000);

        // MTHI+MTLO together writes both halves.
        hilo_wen   = 2'b11;
        hilo_wdata = 32'h1234_5678;
        step();
        hilo_wen = 2'b00;
        check("mt_both", {hi, lo}, 64'h1234_5678_1234_5678);
`ifdef MULT_HILO_ACC_EN
        run_op("madd_neg", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'h1234_5677);
`else
        run_op("madd_neg", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

        // MTHI first, then MTLO coinciding with an accepted MADD 2*3.
        hilo_wen   = 2'b10;
        hilo_wdata = 32'd0;
        step();
        hilo_wen   = 2'b01;
        hilo_wdata = 32'd1;
        mul_valid  = 1'b1;
        mul_op     = 2'b11;
        mul_src1   = 32'd2;
        mul_src2   = 32'd3;
        step();
        hilo_wen  = 2'b00;
        mul_valid = 1'b0;
        check("madd_mtlo", {hi, lo}, 64'd1);
        for (int i = 0; i < LAT; i++) step();
        check("madd_done", 64'(mul_done), 64'd1);
        step();
`ifdef MULT_HILO_ACC_EN
        check("madd_res", {hi, lo}, 64'd7);
`else
        check("madd_res", {hi, lo}, 64'd6);
`endif

        // Back-to-back: request held high across the first op.
        mul_valid = 1'b1;
        mul_op    = 2'b00;
        mul_src1  = 32'd3;
        mul_src2  = 32'd4;
        step();
        check("b2b_ops1", {mult_op1, mult_op2}, {32'd3, 32'd4});
        for (int i = 0; i < LAT; i++) step();
        check("b2b_done1", 64'(mul_done), 64'd1);
        step();
        mul_src1 = 32'd6;
        mul_src2 = 32'd7;
        check("b2b_res1", {hi, lo}, 64'd12);
        check("b2b_ready", 64'(mul_ready), 64'd1);
        step();
        mul_valid  = 1'b0;
        hilo_wen   = 2'b01;
        hilo_wdata = 32'hDEAD_BEEF;
        check("b2b_accept2", {31'd0, mul_ready, mult_op1}, {31'd0, 1'b0, 32'd6});
        step();
        hilo_wen = 2'b00;
        check("busy_mtlo", {hi, lo}, 64'd12);
        for (int i = 1; i < LAT; i++) step();
        check("b2b_done2", 64'(mul_done), 64'd1);
        step();
        check("b2b_res2", {hi, lo}, 64'd42);

        // Reset in cycle 1 of MULT 7*7 aborts it.
        mul_valid = 1'b1;
        mul_op    = 2'b01;
        mul_src1  = 32'd7;
        mul_src2  = 32'd7;
        step();
        mul_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_ctl", {62'd0, mul_ready, mul_done}, 64'd2);
        step();
        resetn   = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (mul_done) done_cnt++;
        end
        check("abort_nodone", 64'(done_cnt), 64'd0);
        check("abort_after", {hi, lo}, 64'd0);
        check("abort_ready", 64'(mul_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
